// File: rtl/pc_sequencer_if.sv
// Command, operand-memory and status bundle for pc_sequencer.
// Signal names keep the block's i_/o_ port naming from the DUT's viewpoint.
interface pc_sequencer_if;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd;
  logic [7:0]  i_offset;
  logic        o_cmd_ready;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [7:0]  i_mem_data;
  logic [15:0] o_pc;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_cmd_valid, i_cmd, i_offset, i_mem_data,
    input  o_cmd_ready, o_mem_rd, o_mem_addr,
    input  o_pc, o_done, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_offset, i_mem_data,
    output o_cmd_ready, o_mem_rd, o_mem_addr,
    output o_pc, o_done, o_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JMP/BRANCH/vector loads via 2-byte reads.
// Define PC_SEQ_PAGE_CROSS_PENALTY_EN for a FIXUP cycle on page-cross branches.
module pc_sequencer (
  input  logic           i_clk,
  input  logic           i_reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_LOAD
`ifdef PC_SEQ_PAGE_CROSS_PENALTY_EN
    , S_FIXUP
`endif
  } state_e;

  localparam logic [2:0] C_INC = 3'd0;
  localparam logic [2:0] C_JMP = 3'd1;
  localparam logic [2:0] C_BR  = 3'd2;
  localparam logic [2:0] C_RST = 3'd3;
  localparam logic [2:0] C_NMI = 3'd4;
  localparam logic [2:0] C_IRQ = 3'd5;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  lo_q, lo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] tgt;

  assign tgt = pc_q + {{8{bus.i_offset[7]}}, bus.i_offset};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_BOOT;
      pc_q    <= 16'h0000;
      addr_q  <= 16'h0000;
      lo_q    <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RD_LO;
        addr_d  = 16'hFFFC;
      end
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          unique case (bus.i_cmd)
            C_INC: begin
              pc_d   = pc_q + 16'd1;
              done_d = 1'b1;
            end
            C_JMP: begin
              state_d = S_RD_LO;
              addr_d  = pc_q;
            end
            C_BR: begin
`ifdef PC_SEQ_PAGE_CROSS_PENALTY_EN
              // Low byte lands first; high byte fixed next cycle.
              if (tgt[15:8] != pc_q[15:8]) begin
                pc_d    = {pc_q[15:8], tgt[7:0]};
                addr_d  = tgt;
                state_d = S_FIXUP;
              end else begin
                pc_d   = tgt;
                done_d = 1'b1;
              end
`else
              pc_d   = tgt;
              done_d = 1'b1;
`endif
            end
            C_RST: begin
              state_d = S_RD_LO;
              addr_d  = 16'hFFFC;
            end
            C_NMI: begin
              state_d = S_RD_LO;
              addr_d  = 16'hFFFA;
            end
            C_IRQ: begin
              state_d = S_RD_LO;
              addr_d  = 16'hFFFE;
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      S_RD_LO: state_d = S_RD_HI;
      S_RD_HI: begin
        lo_d    = bus.i_mem_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pc_d    = {bus.i_mem_data, lo_q};
        lo_d    = 8'h00;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef PC_SEQ_PAGE_CROSS_PENALTY_EN
      S_FIXUP: begin
        pc_d    = addr_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_mem_rd    = (state_q == S_RD_LO) ||
                           (state_q == S_RD_HI);
  assign bus.o_mem_addr  = (state_q == S_RD_LO) ? addr_q :
                           (state_q == S_RD_HI) ? addr_q + 16'd1 :
                           16'h0000;
  assign bus.o_pc        = pc_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random commands
// against a transaction-level PC model and a byte-array memory.
`timescale 1ns/1ps
module tb_pc_sequencer;

`ifdef PC_SEQ_PAGE_CROSS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] mpc;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Operand memory: data valid the cycle after a read, junk otherwise.
  always @(posedge clk) begin
    if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
    else              bus.i_mem_data <= 8'($urandom);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first cycle after the accepting edge.
  // lat = number of busy cycles before completion becomes visible.
  task automatic finish_cmd(input int lat, input bit ld,
                            input logic [15:0] a,
                            input logic [15:0] mid,
                            input logic [15:0] exp,
                            input bit er);
    logic [15:0] a1;
    a1 = a + 16'd1;
    for (int i = 1; i <= lat; i++) begin
      chk("busy_done", bus.o_done, 0);
      chk("busy_ready", bus.o_cmd_ready, 0);
      chk("busy_pc", bus.o_pc, ld ? mpc : mid);
      if (ld) begin
        chk("rd", bus.o_mem_rd, (i < 3) ? 1 : 0);
        chk("addr", bus.o_mem_addr,
            (i == 1) ? a : (i == 2) ? a1 : 16'h0);
      end
      bus.i_cmd_valid = 1'($urandom);
      bus.i_cmd       = 3'($urandom);
      bus.i_offset    = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    chk("done", bus.o_done, 1);
    chk("err", bus.o_err, er);
    chk("pc", bus.o_pc, exp);
    chk("ready", bus.o_cmd_ready, 1);
    chk("rd_idle", bus.o_mem_rd, 0);
    mpc = exp;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [7:0] off);
    logic [15:0] a, t, exp, mid;
    int lat;
    bit ld, er;
    a = 16'h0; mid = mpc; exp = mpc;
    lat = 0; ld = 0; er = 0;
    t = mpc + {{8{off[7]}}, off};
    case (c)
      3'd0: exp = mpc + 16'd1;
      3'd1: begin ld = 1; a = mpc; end
      3'd2: begin
        exp = t;
        if (PEN && t[15:8] != mpc[15:8]) begin
          lat = 1;
          mid = {mpc[15:8], t[7:0]};
        end
      end
      3'd3: begin ld = 1; a = 16'hFFFC; end
      3'd4: begin ld = 1; a = 16'hFFFA; end
      3'd5: begin ld = 1; a = 16'hFFFE; end
      default: er = 1;
    endcase
    if (ld) begin
      lat = 3;
      exp = {mem[16'(a + 16'd1)], mem[a]};
    end
    chk("accept_ready", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    bus.i_offset    = off;
    @(posedge clk);
    @(negedge clk);
    finish_cmd(lat, ld, a, mid, exp, er);
  endtask

  task automatic boot_after_release();
    logic [15:0] exp;
    exp = {mem[16'hFFFD], mem[16'hFFFC]};
    mpc = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    finish_cmd(3, 1, 16'hFFFC, 16'h0, exp, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, bus.o_cmd_ready, 0);
    chk({tag, "_rd"}, bus.o_mem_rd, 0);
    chk({tag, "_addr"}, bus.o_mem_addr, 0);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_err"}, bus.o_err, 0);
    chk({tag, "_pc"}, bus.o_pc, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 3'd0;
    bus.i_offset = 8'd0;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;

    // Reset and boot vector load.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    boot_after_release();
    chk("boot_pc", mpc, 16'h1234);

    // Back-to-back INC.
    do_cmd(3'd0, 8'h00);
    do_cmd(3'd0, 8'h00);
    do_cmd(3'd0, 8'h00);
    chk("inc3", bus.o_pc, 16'h1237);

    // IRQ vector to FFFF, then INC wrap.
    mem[16'hFFFE] = 8'hFF;
    mem[16'hFFFF] = 8'hFF;
    do_cmd(3'd5, 8'h00);
    do_cmd(3'd0, 8'h00);
    chk("inc_wrap", bus.o_pc, 16'h0000);

    // Backward page-cross branch 0000 -> FFFF.
    do_cmd(3'd2, 8'hFF);

    // JMP_ABS with operand address wrap.
    mem[16'hFFFF] = 8'h78;
    mem[16'h0000] = 8'h56;
    do_cmd(3'd1, 8'h00);
    chk("jmp_wrap", bus.o_pc, 16'h5678);

    // Branch page cross 10F0 + 20.
    mem[16'h5678] = 8'hF0;
    mem[16'h5679] = 8'h10;
    do_cmd(3'd1, 8'h00);
    do_cmd(3'd2, 8'h20);
    chk("br_cross", bus.o_pc, 16'h1110);

    // Branch within page 1234 - 2.
    mem[16'h1110] = 8'h34;
    mem[16'h1111] = 8'h12;
    do_cmd(3'd1, 8'h00);
    do_cmd(3'd2, 8'hFE);
    chk("br_back", bus.o_pc, 16'h1232);

    // Illegal commands at 4000.
    mem[16'h1232] = 8'h00;
    mem[16'h1233] = 8'h40;
    do_cmd(3'd1, 8'h00);
    do_cmd(3'd7, 8'h00);
    do_cmd(3'd6, 8'h00);
    chk("illegal_pc", bus.o_pc, 16'h4000);

    // Reset beats a valid command on the same edge.
    rst = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    check_reset_outs("rst_dom");
    rst = 1'b0;
    boot_after_release();

    // Reset during RD_HI of an NMI load.
    chk("nmi_ready", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = 3'd4;
    @(posedge clk);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    chk("nmi_lo", bus.o_mem_addr, 16'hFFFA);
    @(posedge clk);
    @(negedge clk);
    chk("nmi_hi", bus.o_mem_addr, 16'hFFFB);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("nmi_rst");
    rst = 1'b0;
    boot_after_release();
    chk("reboot_pc", mpc, 16'h1234);

    // Random command stream.
    for (int n = 0; n < 300; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: i_clk in 1, rising-edge clock; i_reset in 1, synchronous active-high reset.
REQ-002 i_cmd_valid in 1: command request.
REQ-003 i_cmd in 3: 0 INC, 1 JMP_ABS, 2 BRANCH, 3 VEC_RESET, 4 VEC_NMI, 5 VEC_IRQ, 6-7 illegal.
REQ-004 i_offset in 8: signed branch offset, sampled with BRANCH.
REQ-005 o_cmd_ready out 1: command accepted on an edge with i_cmd_valid && o_cmd_ready.
REQ-006 o_mem_rd out 1, o_mem_addr out 16: operand byte read request; i_mem_data in 8 is valid in the cycle after o_mem_rd (fixed 1-cycle latency).
REQ-007 o_pc out 16: registered program counter.
REQ-008 o_done out 1: one-cycle pulse when a command completes; o_err out 1: one-cycle pulse with o_done for illegal commands.

Function
REQ-009 States: BOOT, IDLE, RD_LO, RD_HI, LOAD, FIXUP; o_cmd_ready=1 only in IDLE.
REQ-010 BOOT: first edge with i_reset=0 enters RD_LO with vector address 16'hFFFC, exactly as VEC_RESET accepted on that edge.
REQ-011 INC accepted at edge k: o_pc<=o_pc+1 at edge k, 16-bit wrap FFFF->0000; stays IDLE; back-to-back INC each cycle allowed.
REQ-012 JMP_ABS operand address A=o_pc; VEC_RESET/NMI/IRQ A=FFFC/FFFA/FFFE.
REQ-013 Two-byte load accepted at edge k: RD_LO (cycle k+1) o_mem_rd=1, addr A; RD_HI (k+2) captures low byte, o_mem_rd=1, addr A+1 with 16-bit wrap; LOAD (k+3) captures high byte; o_pc<={hi,lo} at edge k+3; returns to IDLE.
REQ-014 o_mem_rd=0 and o_mem_addr=16'h0000 outside RD_LO/RD_HI.
REQ-015 BRANCH target T = o_pc + sign-extended i_offset, modulo 2^16; no page cross (T[15:8]==o_pc[15:8]) -> o_pc<=T at acceptance edge, stays IDLE.
REQ-016 BRANCH with page cross: per REQ-029/030.
REQ-017 Illegal cmd: accepted, o_pc unchanged, stays IDLE, o_done=o_err=1 next cycle.
REQ-018 o_done=1 exactly in the first cycle the completed command's o_pc value is visible; 0 otherwise; never during BOOT.
REQ-019 o_err=0 except REQ-017.
REQ-020 i_cmd_valid ignored when o_cmd_ready=0; i_cmd/i_offset sampled only on the acceptance edge.
REQ-021 Temporary low-byte register cleared on completion and reset.

Reset
REQ-022 i_reset=1 at an edge: state<=BOOT, o_pc<=16'h0000, temp<=0.
REQ-023 Reset values: o_cmd_ready=0, o_mem_rd=0, o_mem_addr=0, o_done=0, o_err=0.
REQ-024 Reset in any state, including mid-load or FIXUP, abandons the command without o_done; boot vector load restarts after release.
REQ-025 Reset dominates i_cmd_valid on the same edge.

Configuration
REQ-026 Macro PC_SEQ_PAGE_CROSS_PENALTY_EN selects page-cross branch timing.
REQ-027 Macro affects only REQ-029/030 behaviour.
REQ-028 FIXUP state exists only when defined.
REQ-029 Defined: accepting edge k sets o_pc<={o_pc[15:8],T[7:0]}, enters FIXUP (ready 0); edge k+1 sets o_pc<=T, returns IDLE; o_done in cycle k+2.
REQ-030 Undefined: o_pc<=T at edge k, no extra cycle, same as REQ-015.

Verification
REQ-031 Release reset, mem[FFFC]=34, mem[FFFD]=12 -> reads FFFC then FFFD, o_pc=1234 at edge 3, single o_done, then o_cmd_ready=1.
REQ-032 INC at o_pc=FFFF -> 0000 with o_done next cycle; three back-to-back INC from 1234 -> 1237 after 3 edges.
REQ-033 BRANCH o_pc=10F0 offset 20: macro on -> 1010 then 1110, done one cycle later; off -> 1110 in one edge; o_pc=1234 offset FE -> 1232, one edge.
REQ-034 JMP_ABS at o_pc=FFFF, mem[FFFF]=78, mem[0000]=56 -> reads FFFF, 0000; o_pc=5678.
REQ-035 VEC_NMI, i_reset pulsed during RD_HI -> o_pc=0000, no o_done, boot reload from FFFC/FFFD follows.
REQ-036 i_cmd=7 at o_pc=4000 -> o_done=o_err=1 one cycle, o_pc stays 4000.
